lsu_dmem_ctrl: RTL
==================

# lsu_dmem_ctrl

Load/store controller that sits between the core's execute stage and the data memory, acting as the initiator on the DMEM port (word address, write enable, write data, synchronous read data). It converts byte/half/word loads and stores into word-wide DMEM transactions. Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended and returned to the core with a one-cycle done pulse.

## Interface
Parameters:
- n, 32: data width of the core and DMEM words.
- address, 11: DMEM word-address width.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- req_i  in  1  access request from the core, sampled only while ready_o=1.
- we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  size and sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  n  byte address.
- wdata_i  in  n  store data, right-aligned.
- ready_o  out  1  controller is idle and can accept a request.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; access was rejected.
- rdata_o  out  n  extended load data, valid while done_o=1 and held until the next load completes.
- mem_addr_o  out  address  DMEM word address, equal to addr_i[address+1:2].
- mem_st_data_o  out  n  DMEM write word.
- mem_st_en_o  out  1  DMEM write enable.
- mem_ld_data_i  in  n  DMEM read word, valid one cycle after mem_addr_o is sampled.

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - ready_o=1.
  - On req_i: latch we_i, funct3_i, addr_i[1:0] and wdata_i, and register mem_addr_o.
  - Illegal request: funct3 in {011, 110, 111}, or a store with funct3[2]=1. Go to DONE with err_o=1 and make no memory access.
  - SW goes to WR.
  - All loads, SB and SH go to RD.
- RD: the address is presented to DMEM. Go to WAIT.
- WAIT:
  - mem_ld_data_i is valid in this cycle.
  - Load: select the byte or half using the latched addr[1:0], extend it per funct3, register it into rdata_o, then go to DONE.
  - Store: register the merged word into mem_st_data_o, then go to WR.
  - Merge rule: replace byte lane addr[1:0] (SB) or half lane addr[1] (SH) with the low bits of wdata_i; all other lanes keep the read data.
- WR: mem_st_en_o=1 for exactly this one cycle. Go to DONE.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
- A request raised in any state other than IDLE is ignored; the core must hold it until ready_o=1.
- Address bits above address+1 are dropped, so accesses wrap modulo DMEM size.
- The controller never writes during a load. rdata_o does not change on a store.

## Timing
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - ready_o=1.
  - done_o=0, err_o=0, mem_st_en_o=0.
  - rdata_o=0, mem_addr_o=0, mem_st_data_o=0.
- Reset asserted mid-operation aborts immediately. If it falls before the WR rising edge, no write occurs. mem_st_en_o is cleared combinationally by reset.
- Latency, counted from the accept edge T (req_i high with ready_o=1):
  - Load: done_o in cycle T+3.
  - SW: mem_st_en_o in T+1, done_o in T+2.
  - SB/SH: mem_st_en_o in T+3, done_o in T+4.
  - Rejected access: done_o with err_o in T+1.
- ready_o=0 from T+1 until the cycle after DONE. Back-to-back accesses are therefore spaced by at least one IDLE cycle.
- mem_addr_o is stable from T+1 until the next accept.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00, is rejected: DONE with err_o=1 at T+1 and no DMEM access.
- LSU_MISALIGN_TRAP_EN undefined:
  - A misaligned address is silently aligned down (H clears addr[0], W clears addr[1:0]) and the access proceeds normally.
  - err_o is raised only for illegal funct3.

## Test plan
- Reset then SW: addr=0x0000_0010, wdata=0xDEAD_BEEF → mem_addr_o=4, mem_st_en_o=1 with mem_st_data_o=0xDEADBEEF at T+1, done_o at T+2.
- LB, LBU, LH: DMEM word 4 = 0x80F0_7F81.
  - LB at 0x10 → rdata_o=0xFFFF_FF81.
  - LBU at 0x10 → 0x0000_0081.
  - LH at 0x12 → 0xFFFF_80F0.
  - Each with done_o at T+3.
- SB at 0x13, wdata=0x0000_00AA over word 0x11223344 → written word 0xAA223344 at T+3, done_o at T+4. A following LW returns 0xAA223344.
- LW at 0x0000_0011:
  - With LSU_MISALIGN_TRAP_EN → err_o=1 at T+1 and mem_st_en_o never asserts.
  - Without the macro → reads word 4 and err_o=0.
- funct3=011 load → err_o=1 at T+1. A req_i held high during RD/WAIT/WR is not accepted until ready_o returns.
- Assert rst_ni=0 during WAIT of an SH → no mem_st_en_o pulse, all outputs at reset values, and the next SW completes normally.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dmem_ctrl
//  Purpose  : Load/store controller between the core execute stage and a
//             word-wide, synchronous-read data memory. Byte/half/word loads
//             are extracted and sign/zero extended; sub-word stores are done
//             as read-modify-write; word stores write directly.
//  Ports    : clk_i, rst_ni          clock, async active-low reset
//             req_i, we_i, funct3_i, addr_i, wdata_i   core request
//             ready_o, done_o, err_o, rdata_o          core response
//             mem_addr_o, mem_st_data_o, mem_st_en_o, mem_ld_data_i   DMEM
//  Config   : LSU_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses are
//             rejected with err_o; otherwise they are aligned down silently.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_dmem_ctrl #(
   parameter int N       = 32,   // core / DMEM data width
   parameter int ADDRESS = 11    // DMEM word-address width
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [2:0]         funct3_i,
   input  logic [N-1:0]       addr_i,
   input  logic [N-1:0]       wdata_i,
   output logic               ready_o,
   output logic               done_o,
   output logic               err_o,
   output logic [N-1:0]       rdata_o,
   output logic [ADDRESS-1:0] mem_addr_o,
   output logic [N-1:0]       mem_st_data_o,
   output logic               mem_st_en_o,
   input  logic [N-1:0]       mem_ld_data_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state_q, state_d;
   logic               we_q, we_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [1:0]         off_q, off_d;
   logic [N-1:0]       wdata_q, wdata_d;
   logic               err_q, err_d;
   logic [N-1:0]       rdata_q, rdata_d;
   logic [ADDRESS-1:0] maddr_q, maddr_d;
   logic [N-1:0]       st_data_q, st_data_d;

   logic               req_err;
   logic [1:0]         req_off;
   logic               is_sw;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic [N-1:0]       ld_ext;
   logic [N-1:0]       merged;

   // Address bits above the DMEM range are dropped on purpose (wrap-around).
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_i[N-1:ADDRESS+2];

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   always_comb begin
      logic illegal;
      logic misalign;
      // 011, 110, 111 are undefined; unsigned variants only exist for loads.
      illegal  = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                 (we_i && funct3_i[2]);
      misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`endif
      req_err = illegal || misalign;

      // Lane offset used later; misaligned H/W is aligned down here.
      case (funct3_i[1:0])
         2'b00:   req_off = addr_i[1:0];
         2'b01:   req_off = {addr_i[1], 1'b0};
         default: req_off = 2'b00;
      endcase

      is_sw = we_i && (funct3_i == 3'b010);
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         off_q     <= 2'b00;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         maddr_q   <= '0;
         st_data_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         funct3_q  <= funct3_d;
         off_q     <= off_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         maddr_q   <= maddr_d;
         st_data_q <= st_data_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (req_err)    state_d = S_DONE;
               else if (is_sw) state_d = S_WR;
               else            state_d = S_RD;
            end
         end
         S_RD:    state_d = S_WAIT;
         S_WAIT:  state_d = we_q ? S_WR : S_DONE;
         S_WR:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load extraction and store merge on the word returned by DMEM
   // ---------------------------------------------------------------------
   always_comb begin
      case (off_q)
         2'b00:   ld_byte = mem_ld_data_i[7:0];
         2'b01:   ld_byte = mem_ld_data_i[15:8];
         2'b10:   ld_byte = mem_ld_data_i[23:16];
         default: ld_byte = mem_ld_data_i[31:24];
      endcase
      ld_half = off_q[1] ? mem_ld_data_i[31:16] : mem_ld_data_i[15:0];

      case (funct3_q)
         3'b000:  ld_ext = {{(N-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {{(N-8){1'b0}}, ld_byte};
         3'b001:  ld_ext = {{(N-16){ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {{(N-16){1'b0}}, ld_half};
         default: ld_ext = mem_ld_data_i;
      endcase

      merged = mem_ld_data_i;
      if (funct3_q[1:0] == 2'b00)
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // ---------------------------------------------------------------------
   // Datapath register updates
   // ---------------------------------------------------------------------
   always_comb begin
      we_d      = we_q;
      funct3_d  = funct3_q;
      off_d     = off_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      maddr_d   = maddr_q;
      st_data_d = st_data_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               we_d     = we_i;
               funct3_d = funct3_i;
               off_d    = req_off;
               wdata_d  = wdata_i;
               err_d    = req_err;
               maddr_d  = addr_i[ADDRESS+1:2];
               // A word store needs no read; its data is ready for WR now.
               if (is_sw && !req_err)
                  st_data_d = wdata_i;
            end
         end
         S_WAIT: begin
            if (we_q) st_data_d = merged;
            else      rdata_d   = ld_ext;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      ready_o       = (state_q == S_IDLE);
      done_o        = (state_q == S_DONE);
      err_o         = (state_q == S_DONE) && err_q;
      // Gated by reset so the write strobe drops the instant reset asserts.
      mem_st_en_o   = (state_q == S_WR) && rst_ni;
      rdata_o       = rdata_q;
      mem_addr_o    = maddr_q;
      mem_st_data_o = st_data_q;
   end

endmodule
`default_nettype wire
